// File: rtl/dram_arb_pkg.sv
// Shared encodings for the data-memory port arbiter: FSM states and master IDs.
package dram_arb_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OWN0 = 2'd1;
   localparam logic [1:0] ST_OWN1 = 2'd2;

   localparam logic M_CPU = 1'b0;
   localparam logic M_CAP = 1'b1;

   typedef enum logic [1:0] {
      StIdle = ST_IDLE,
      StOwn0 = ST_OWN0,
      StOwn1 = ST_OWN1
   } arb_state_e;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats a same-cycle increment.
module arb_sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin, lockable two-master arbiter (CPU / capture engine) for the data-memory port.
// Optional usage counters are built when ARB_STATS_EN is defined.
module dram_port_arbiter
   import dram_arb_pkg::*;
#(
   parameter int unsigned AW       = 8,
   parameter int unsigned DW       = 8,
   parameter int unsigned MAX_LOCK = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
`ifdef ARB_STATS_EN
   input  logic          stat_clr_i,
   output logic [15:0]   stat_gnt0_o,
   output logic [15:0]   stat_gnt1_o,
   output logic [7:0]    stat_force_o,
`endif
   input  logic          req0_i,
   input  logic          lock0_i,
   input  logic [AW-1:0] addr0_i,
   input  logic [DW-1:0] data0_i,
   input  logic          mw0_i,
   output logic          gnt0_o,
   output logic          ack0_o,
   output logic [DW-1:0] q0_o,
   input  logic          req1_i,
   input  logic          lock1_i,
   input  logic [AW-1:0] addr1_i,
   input  logic [DW-1:0] data1_i,
   input  logic          mw1_i,
   output logic          gnt1_o,
   output logic          ack1_o,
   output logic [DW-1:0] q1_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_data_o,
   output logic          mem_mw_o,
   input  logic [DW-1:0] mem_q_i
);

   localparam int unsigned CW = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
   localparam logic [CW-1:0] LockMax = CW'(MAX_LOCK - 1);

   arb_state_e    state_q, state_d;
   logic          rr_last_q, rr_last_d;
   logic [CW-1:0] lock_cnt_q, lock_cnt_d;
   logic          own_id, own_req, own_lock, oth_req;
   logic          force_rel;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         rr_last_q  <= M_CAP;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_last_q  <= rr_last_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   // View the current owner's signals uniformly so both OWN states share one rule set.
   assign own_id   = (state_q == StOwn1);
   assign own_req  = own_id ? req1_i  : req0_i;
   assign own_lock = own_id ? lock1_i : lock0_i;
   assign oth_req  = own_id ? req0_i  : req1_i;

   always_comb begin
      state_d    = state_q;
      rr_last_d  = rr_last_q;
      lock_cnt_d = lock_cnt_q;
      force_rel  = 1'b0;
      unique case (state_q)
         StIdle: begin
            lock_cnt_d = '0;
            if (req0_i && req1_i) begin
               state_d = (rr_last_q == M_CPU) ? StOwn1 : StOwn0;
            end else if (req0_i) begin
               state_d = StOwn0;
            end else if (req1_i) begin
               state_d = StOwn1;
            end
         end
         StOwn0, StOwn1: begin
            if (own_lock && own_req && (lock_cnt_q < LockMax)) begin
               lock_cnt_d = lock_cnt_q + 1'b1;
            end else if (oth_req) begin
               state_d    = own_id ? StOwn0 : StOwn1;
               rr_last_d  = own_id;
               lock_cnt_d = '0;
               force_rel  = own_lock && own_req;
            end else if (own_req) begin
               if (lock_cnt_q < LockMax) begin
                  lock_cnt_d = lock_cnt_q + 1'b1;
               end
            end else begin
               state_d    = StIdle;
               rr_last_d  = own_id;
               lock_cnt_d = '0;
            end
         end
         default: begin
            state_d    = StIdle;
            lock_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      gnt0_o     = (state_q == StOwn0);
      gnt1_o     = (state_q == StOwn1);
      ack0_o     = req0_i & gnt0_o;
      ack1_o     = req1_i & gnt1_o;
      mem_addr_o = '0;
      mem_data_o = '0;
      if (gnt0_o) begin
         mem_addr_o = addr0_i;
         mem_data_o = data0_i;
      end else if (gnt1_o) begin
         mem_addr_o = addr1_i;
         mem_data_o = data1_i;
      end
      mem_mw_o = (mw0_i & ack0_o) | (mw1_i & ack1_o);
      q0_o     = (ack0_o && !mw0_i) ? mem_q_i : '0;
      q1_o     = (ack1_o && !mw1_i) ? mem_q_i : '0;
   end

`ifdef ARB_STATS_EN
   arb_sat_counter #(.W(16)) u_stat_gnt0 (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (ack0_o),
      .clr_i (stat_clr_i),
      .cnt_o (stat_gnt0_o)
   );

   arb_sat_counter #(.W(16)) u_stat_gnt1 (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (ack1_o),
      .clr_i (stat_clr_i),
      .cnt_o (stat_gnt1_o)
   );

   arb_sat_counter #(.W(8)) u_stat_force (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (force_rel),
      .clr_i (stat_clr_i),
      .cnt_o (stat_force_o)
   );
`else
   logic unused_force;
   assign unused_force = force_rel;
`endif

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: grant table, scoreboarded reads, lock expiry, write-back and reset abort.
module tb_dram_port_arbiter;

   logic       clk, rst;
   logic       req0, lock0, mw0, req1, lock1, mw1;
   logic [7:0] addr0, data0, addr1, data1;
   logic       gnt0, ack0, gnt1, ack1;
   logic [7:0] q0, q1, mem_addr, mem_data, mem_q;
   logic       mem_mw;
`ifdef ARB_STATS_EN
   logic        stat_clr;
   logic [15:0] stat_gnt0, stat_gnt1;
   logic [7:0]  stat_force;
`endif

   int total = 0;
   int bad   = 0;

   logic [7:0] mem [256];
   bit [255:0] wr_vld;
   bit [7:0]   ref_mem [256];
   logic [7:0] q0_exp [$];
   logic [7:0] q1_exp [$];
   bit         sb_en = 1'b0;

   // Field order: r0 r1 l0 l1 g0 g1
   typedef struct packed {
      logic r0, r1, l0, l1, g0, g1;
   } vec_t;
   vec_t tbl [16];

   dram_port_arbiter #(.AW(8), .DW(8), .MAX_LOCK(4)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
`ifdef ARB_STATS_EN
      .stat_clr_i   (stat_clr),
      .stat_gnt0_o  (stat_gnt0),
      .stat_gnt1_o  (stat_gnt1),
      .stat_force_o (stat_force),
`endif
      .req0_i       (req0),
      .lock0_i      (lock0),
      .addr0_i      (addr0),
      .data0_i      (data0),
      .mw0_i        (mw0),
      .gnt0_o       (gnt0),
      .ack0_o       (ack0),
      .q0_o         (q0),
      .req1_i       (req1),
      .lock1_i      (lock1),
      .addr1_i      (addr1),
      .data1_i      (data1),
      .mw1_i        (mw1),
      .gnt1_o       (gnt1),
      .ack1_o       (ack1),
      .q1_o         (q1),
      .mem_addr_o   (mem_addr),
      .mem_data_o   (mem_data),
      .mem_mw_o     (mem_mw),
      .mem_q_i      (mem_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BCD table contents: address a holds BCD of (4a+1) mod 100, so address 4 holds 0x17.
   function automatic logic [7:0] bcd_init(input logic [7:0] a);
      int v;
      v = (int'(a) * 4 + 1) % 100;
      return 8'((v / 10) * 16 + (v % 10));
   endfunction

   assign mem_q = wr_vld[mem_addr] ? mem[mem_addr] : bcd_init(mem_addr);

   always @(posedge clk) begin
      if (mem_mw) begin
         mem[mem_addr]    <= mem_data;
         wr_vld[mem_addr] <= 1'b1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Read-data scoreboard: every ACKed read pops its expectation; otherwise Qn must be 0.
   always @(negedge clk) begin
      logic [7:0] e;
      if (sb_en && !rst) begin
         if (ack0 && !mw0) begin
            if (q0_exp.size() == 0) begin
               total++;
               bad++;
               $display("FAIL q0_unexpected: read ack at addr %0h, got %0h expected none", addr0, q0);
            end else begin
               e = q0_exp.pop_front();
               check("q0_data", q0, e);
            end
         end else begin
            check("q0_idle_zero", q0, 0);
         end
         if (ack1 && !mw1) begin
            if (q1_exp.size() == 0) begin
               total++;
               bad++;
               $display("FAIL q1_unexpected: read ack at addr %0h, got %0h expected none", addr1, q1);
            end else begin
               e = q1_exp.pop_front();
               check("q1_data", q1, e);
            end
         end else begin
            check("q1_idle_zero", q1, 0);
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic do_access(input bit m, input logic [7:0] a, input logic w,
                            input logic [7:0] d, output int lat);
      bit seen;
      seen = 1'b0;
      lat  = 0;
      if (!w) begin
         if (m) q1_exp.push_back(ref_mem[a]);
         else   q0_exp.push_back(ref_mem[a]);
      end
      if (m) begin
         addr1 = a; data1 = d; mw1 = w; req1 = 1'b1;
      end else begin
         addr0 = a; data0 = d; mw0 = w; req0 = 1'b1;
      end
      for (int i = 1; i <= 8 && !seen; i++) begin
         @(posedge clk);
         #2;
         if ((m ? ack1 : ack0) === 1'b1) begin
            seen = 1'b1;
            lat  = i;
         end
      end
      check("acc_ack_seen", seen, 1);
      if (seen) begin
         check("acc_gnt_other", m ? gnt0 : gnt1, 0);
         check("acc_mem_addr", mem_addr, a);
         check("acc_mem_mw", mem_mw, w);
         if (w) begin
            check("acc_mem_data", mem_data, d);
            ref_mem[a] = d;
         end
      end
      @(posedge clk);
      #1;
      if (m) req1 = 1'b0;
      else   req0 = 1'b0;
      #1;
      check("acc_single_ack", m ? ack1 : ack0, 0);
      check("acc_mw_one_cycle", mem_mw, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lat, n_ack0;
      bit got1;
      for (int i = 0; i < 256; i++) ref_mem[i] = bcd_init(8'(i));
      tbl[0]  = 6'b110010;  tbl[1]  = 6'b000000;  tbl[2]  = 6'b110001;  tbl[3]  = 6'b110010;
      tbl[4]  = 6'b110001;  tbl[5]  = 6'b110010;  tbl[6]  = 6'b000000;  tbl[7]  = 6'b010001;
      tbl[8]  = 6'b010001;  tbl[9]  = 6'b100010;  tbl[10] = 6'b000000;  tbl[11] = 6'b001000;
      tbl[12] = 6'b010101;  tbl[13] = 6'b110101;  tbl[14] = 6'b110010;  tbl[15] = 6'b000000;

      // Requests and writes asserted during reset must not grant, ack or write.
      rst = 1'b1;
      req0 = 1'b1; lock0 = 1'b0; mw0 = 1'b1; addr0 = 8'd7; data0 = 8'hAA;
      req1 = 1'b1; lock1 = 1'b0; mw1 = 1'b1; addr1 = 8'd9; data1 = 8'hBB;
`ifdef ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #2;
      check("rst_gnt0", gnt0, 0);
      check("rst_gnt1", gnt1, 0);
      check("rst_ack0", ack0, 0);
      check("rst_ack1", ack1, 0);
      check("rst_mem_mw", mem_mw, 0);
`ifdef ARB_STATS_EN
      check("rst_stat_gnt0", stat_gnt0, 0);
      check("rst_stat_force", stat_force, 0);
`endif
      req0 = 1'b0; req1 = 1'b0; mw0 = 1'b0; mw1 = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      sb_en = 1'b1;

      // Single CPU read from idle: one-cycle latency, data 0x17 checked by the scoreboard.
      do_access(1'b0, 8'd4, 1'b0, 8'h00, lat);
      check("t1_latency", lat, 1);

      // Cycle-by-cycle grant table starting from a fresh reset (CPU wins first tie).
      sb_en = 1'b0;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         req0 = tbl[i].r0; req1 = tbl[i].r1; lock0 = tbl[i].l0; lock1 = tbl[i].l1;
         @(posedge clk);
         #2;
         check($sformatf("tbl%0d_gnt0", i), gnt0, tbl[i].g0);
         check($sformatf("tbl%0d_gnt1", i), gnt1, tbl[i].g1);
         check($sformatf("tbl%0d_ack0", i), ack0, tbl[i].r0 & tbl[i].g0);
         check($sformatf("tbl%0d_ack1", i), ack1, tbl[i].r1 & tbl[i].g1);
      end
      req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
      @(posedge clk);
      #1;
      sb_en = 1'b1;

      // Locked CPU with capture waiting: exactly MAX_LOCK CPU acks, then direct hand-over.
`ifdef ARB_STATS_EN
      stat_clr = 1'b1;
      @(posedge clk);
      #1 stat_clr = 1'b0;
`endif
      repeat (4) q0_exp.push_back(ref_mem[4]);
      q1_exp.push_back(ref_mem[5]);
      addr0 = 8'd4; mw0 = 1'b0; lock0 = 1'b1; req0 = 1'b1;
      @(posedge clk);
      #2;
      check("t4_gnt0_first", gnt0, 1);
      n_ack0 = ack0 ? 1 : 0;
      addr1 = 8'd5; mw1 = 1'b0; req1 = 1'b1;
      got1 = 1'b0;
      for (int i = 0; i < 10 && !got1; i++) begin
         @(posedge clk);
         #2;
         if (gnt1) got1 = 1'b1;
         else if (ack0) n_ack0++;
      end
      check("t4_gnt1_after_lock", got1, 1);
      check("t4_ack0_count", n_ack0, 4);
      check("t4_gnt0_released", gnt0, 0);
      req0 = 1'b0; lock0 = 1'b0;
      @(posedge clk);
      #1 req1 = 1'b0;
      @(posedge clk);
      #1;
`ifdef ARB_STATS_EN
      check("t4_stat_force", stat_force, 1);
`endif

      // Capture write to 60, then CPU reads it back.
      do_access(1'b1, 8'd60, 1'b1, 8'h72, lat);
      do_access(1'b0, 8'd60, 1'b0, 8'h00, lat);

      // Asynchronous reset in the middle of a capture write aborts it before the next edge.
      addr1 = 8'd100; data1 = 8'h55; mw1 = 1'b1; req1 = 1'b1;
      @(posedge clk);
      #2;
      check("t6_gnt1_before", gnt1, 1);
      check("t6_mw_before", mem_mw, 1);
      #1 rst = 1'b1;
      #1;
      check("t6_gnt1_dropped", gnt1, 0);
      check("t6_ack1_dropped", ack1, 0);
      check("t6_mw_dropped", mem_mw, 0);
`ifdef ARB_STATS_EN
      check("t6_stat_gnt0", stat_gnt0, 0);
      check("t6_stat_gnt1", stat_gnt1, 0);
      check("t6_stat_force", stat_force, 0);
`endif
      req1 = 1'b0; mw1 = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      check("t6_idle_gnt0", gnt0, 0);
      check("t6_idle_gnt1", gnt1, 0);
      do_access(1'b0, 8'd100, 1'b0, 8'h00, lat);
      check("t6_post_latency", lat, 1);

      @(posedge clk);
      #1;
      check("sb_q0_drained", q0_exp.size(), 0);
      check("sb_q1_drained", q1_exp.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule
